tag_fill_unit: RTL and testbench

TAG_FILL_UNIT -- requirements
Module: tag_fill_unit

---
 rtl/tag_fill_pkg.sv | 46 ++++
 rtl/tag_fill_unit_victim_select.sv | 68 ++++++
 rtl/tag_fill_unit.sv | 238 +++++++++++++++++++++++
 tb/tb_tag_fill_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tag_fill_pkg.sv
// Shared types and constants for the tag fill unit; TAG_FILL_PLRU_EN selects
// tree pseudo-LRU replacement instead of the default round-robin pointer.
package tag_fill_pkg;

    localparam int WAYS               = 4;
    localparam int TAG_BITS_DEFAULT   = 10;
    localparam int INDEX_BITS_DEFAULT = 4;

`ifdef TAG_FILL_PLRU_EN
    localparam int POLICY_BITS = 3;
`else
    localparam int POLICY_BITS = 2;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        EVICT  = 2'd2,
        WRITE  = 2'd3
    } fillState_e;

    // Tree leaves are paired {0,2} (bit0=0) and {1,3} (bit0=1); bit1/bit2 pick within a pair.
    function automatic logic [1:0] plruVictim(input logic [2:0] tree);
        logic [1:0] way;
        if (tree[0] == 1'b0) begin
            way = tree[1] ? 2'd2 : 2'd0;
        end else begin
            way = tree[2] ? 2'd3 : 2'd1;
        end
        return way;
    endfunction

    function automatic logic [2:0] plruTouch(input logic [2:0] tree, input logic [1:0] way);
        logic [2:0] next;
        next = tree;
        if (way[0] == 1'b0) begin
            next[0] = 1'b1;
            next[1] = (way == 2'd0);
        end else begin
            next[0] = 1'b0;
            next[2] = (way == 2'd1);
        end
        return next;
    endfunction

endpackage

// File: rtl/tag_fill_unit_victim_select.sv
// Combinational victim choice: same-tag hit, else lowest invalid way, else policy way.
module victim_select
    import tag_fill_pkg::*;
#(
    parameter int tagBits = TAG_BITS_DEFAULT
) (
    input  logic [WAYS-1:0]         setValid,
    input  logic [WAYS*tagBits-1:0] setTags,
    input  logic [tagBits-1:0]      matchTag,
    input  logic [POLICY_BITS-1:0]  policy,
    output logic [1:0]              victimWay,
    output logic                    tagHit,
    output logic                    policyUsed
);

    logic       hitFound_s;
    logic [1:0] hitWay_s;
    logic       freeFound_s;
    logic [1:0] freeWay_s;
    logic [1:0] policyWay_s;

    // Scan from the top way down so the lowest-numbered candidate wins.
    always_comb begin
        hitFound_s  = 1'b0;
        hitWay_s    = 2'd0;
        freeFound_s = 1'b0;
        freeWay_s   = 2'd0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (setValid[w] && (setTags[w*tagBits +: tagBits] == matchTag)) begin
                hitFound_s = 1'b1;
                hitWay_s   = 2'(w);
            end else begin
                hitFound_s = hitFound_s;
            end
            if (!setValid[w]) begin
                freeFound_s = 1'b1;
                freeWay_s   = 2'(w);
            end else begin
                freeFound_s = freeFound_s;
            end
        end
    end

    // Decode the replacement state into a way.
    always_comb begin
`ifdef TAG_FILL_PLRU_EN
        policyWay_s = plruVictim(policy);
`else
        policyWay_s = policy;
`endif
    end

    // Apply the priority order.
    always_comb begin
        tagHit = hitFound_s;
        if (hitFound_s) begin
            victimWay  = hitWay_s;
            policyUsed = 1'b0;
        end else if (freeFound_s) begin
            victimWay  = freeWay_s;
            policyUsed = 1'b0;
        end else begin
            victimWay  = policyWay_s;
            policyUsed = 1'b1;
        end
    end

endmodule

// File: rtl/tag_fill_unit.sv
// Cache tag fill unit: victim choice, dirty-victim handshake and tag/valid/dirty store.
// Define TAG_FILL_PLRU_EN for tree pseudo-LRU replacement (default: round-robin).
module tag_fill_unit
    import tag_fill_pkg::*;
#(
    parameter int tagBits   = TAG_BITS_DEFAULT,
    parameter int indexBits = INDEX_BITS_DEFAULT,
    parameter int ways      = WAYS
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    fillReq,
    output logic                    fillReady,
    input  logic [indexBits-1:0]    fillIndex,
    input  logic [tagBits-1:0]      fillTag,
    input  logic                    fillDirty,
    output logic                    fillDone,
    output logic [1:0]              fillWay,
    output logic                    evictValid,
    input  logic                    evictReady,
    output logic [tagBits-1:0]      evictTag,
    output logic [indexBits-1:0]    evictIndex,
    input  logic [indexBits-1:0]    lookupIndex,
    output logic [WAYS*tagBits-1:0] cacheTag,
    output logic [WAYS-1:0]         cacheValid,
    input  logic                    touchValid,
    input  logic [indexBits-1:0]    touchIndex,
    input  logic [1:0]              touchWay
);

    localparam int SETS = 1 << indexBits;

    logic [tagBits-1:0]     tagMem_r    [SETS][WAYS];
    logic [WAYS-1:0]        validMem_r  [SETS];
    logic [WAYS-1:0]        dirtyMem_r  [SETS];
    logic [POLICY_BITS-1:0] policyMem_r [SETS];

    fillState_e             state_r;
    logic                   fillReady_r;
    logic                   fillDone_r;
    logic [1:0]             fillWay_r;
    logic                   evictValid_r;
    logic [tagBits-1:0]     evictTag_r;
    logic [indexBits-1:0]   evictIndex_r;
    logic [indexBits-1:0]   fillIndex_r;
    logic [tagBits-1:0]     fillTag_r;
    logic                   fillDirty_r;
    logic                   tagHit_r;
    logic [WAYS*tagBits-1:0] cacheTag_r;
    logic [WAYS-1:0]        cacheValid_r;

    logic [WAYS*tagBits-1:0] lookupTags_s;
    logic [WAYS*tagBits-1:0] selTags_s;
    logic [WAYS-1:0]        selValid_s;
    logic [1:0]             victimWay_s;
    logic                   tagHit_s;
    logic                   policyUsed_s;
    logic [tagBits-1:0]     victimTag_s;
    logic                   needEvict_s;
    logic                   writeNow_s;
    logic                   newDirty_s;
    logic [POLICY_BITS-1:0] fillPolicy_s;

`ifdef TAG_FILL_PLRU_EN
    logic [POLICY_BITS-1:0] touchPolicy_s;
    logic                   unusedPolicyUsed_s;
    assign unusedPolicyUsed_s = policyUsed_s;
`else
    logic                   policyUsed_r;
    logic                   unusedTouch_s;
    assign unusedTouch_s = ^{touchValid, touchIndex, touchWay};
`endif

    assign fillReady  = fillReady_r;
    assign fillDone   = fillDone_r;
    assign fillWay    = fillWay_r;
    assign evictValid = evictValid_r;
    assign evictTag   = evictTag_r;
    assign evictIndex = evictIndex_r;
    assign cacheTag   = cacheTag_r;
    assign cacheValid = cacheValid_r;

    // Flatten the tags of the lookup set and of the set being filled.
    always_comb begin
        lookupTags_s = {(WAYS*tagBits){1'b0}};
        selTags_s    = {(WAYS*tagBits){1'b0}};
        for (int w = 0; w < ways; w++) begin
            lookupTags_s[w*tagBits +: tagBits] = tagMem_r[lookupIndex][w];
            selTags_s[w*tagBits +: tagBits]    = tagMem_r[fillIndex_r][w];
        end
    end

    assign selValid_s  = validMem_r[fillIndex_r];
    assign victimTag_s = tagMem_r[fillIndex_r][victimWay_s];
    assign needEvict_s = selValid_s[victimWay_s] && dirtyMem_r[fillIndex_r][victimWay_s]
                         && (victimTag_s != fillTag_r);
    assign writeNow_s  = (state_r == WRITE);
    // A same-tag refill keeps any dirtiness the line already had.
    assign newDirty_s  = fillDirty_r | (tagHit_r & dirtyMem_r[fillIndex_r][fillWay_r]);

    victim_select #(
        .tagBits    (tagBits)
    ) u_victim_select (
        .setValid   (selValid_s),
        .setTags    (selTags_s),
        .matchTag   (fillTag_r),
        .policy     (policyMem_r[fillIndex_r]),
        .victimWay  (victimWay_s),
        .tagHit     (tagHit_s),
        .policyUsed (policyUsed_s)
    );

    // Next replacement state; a touch to the set being written layers on the fill update.
    always_comb begin
        fillPolicy_s = policyMem_r[fillIndex_r];
`ifdef TAG_FILL_PLRU_EN
        fillPolicy_s = plruTouch(fillPolicy_s, fillWay_r);
        if (writeNow_s && (touchIndex == fillIndex_r)) begin
            touchPolicy_s = plruTouch(fillPolicy_s, touchWay);
        end else begin
            touchPolicy_s = plruTouch(policyMem_r[touchIndex], touchWay);
        end
`else
        if (policyUsed_r) begin
            fillPolicy_s = fillPolicy_s + 2'd1;
        end else begin
            fillPolicy_s = fillPolicy_s;
        end
`endif
    end

    // Fill sequencer with registered handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            fillReady_r  <= 1'b1;
            fillDone_r   <= 1'b0;
            fillWay_r    <= 2'd0;
            evictValid_r <= 1'b0;
            evictTag_r   <= {tagBits{1'b0}};
            evictIndex_r <= {indexBits{1'b0}};
            fillIndex_r  <= {indexBits{1'b0}};
            fillTag_r    <= {tagBits{1'b0}};
            fillDirty_r  <= 1'b0;
            tagHit_r     <= 1'b0;
`ifndef TAG_FILL_PLRU_EN
            policyUsed_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (fillReq && fillReady_r) begin
                        fillIndex_r <= fillIndex;
                        fillTag_r   <= fillTag;
                        fillDirty_r <= fillDirty;
                        fillReady_r <= 1'b0;
                        state_r     <= SELECT;
                    end
                end
                SELECT: begin
                    fillWay_r <= victimWay_s;
                    tagHit_r  <= tagHit_s;
`ifndef TAG_FILL_PLRU_EN
                    policyUsed_r <= policyUsed_s;
`endif
                    if (needEvict_s) begin
                        evictValid_r <= 1'b1;
                        evictTag_r   <= victimTag_s;
                        evictIndex_r <= fillIndex_r;
                        state_r      <= EVICT;
                    end else begin
                        fillDone_r <= 1'b1;
                        state_r    <= WRITE;
                    end
                end
                EVICT: begin
                    if (evictReady) begin
                        evictValid_r <= 1'b0;
                        fillDone_r   <= 1'b1;
                        state_r      <= WRITE;
                    end
                end
                WRITE: begin
                    fillDone_r  <= 1'b0;
                    fillReady_r <= 1'b1;
                    state_r     <= IDLE;
                end
                default: begin
                    fillDone_r   <= 1'b0;
                    evictValid_r <= 1'b0;
                    fillReady_r  <= 1'b1;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    // Valid, dirty and replacement state; cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                validMem_r[s]  <= {WAYS{1'b0}};
                dirtyMem_r[s]  <= {WAYS{1'b0}};
                policyMem_r[s] <= {POLICY_BITS{1'b0}};
            end
        end else begin
            if (writeNow_s) begin
                validMem_r[fillIndex_r][fillWay_r] <= 1'b1;
                dirtyMem_r[fillIndex_r][fillWay_r] <= newDirty_s;
                policyMem_r[fillIndex_r]           <= fillPolicy_s;
            end
`ifdef TAG_FILL_PLRU_EN
            if (touchValid) begin
                policyMem_r[touchIndex] <= touchPolicy_s;
            end
`endif
        end
    end

    // Tag array; contents are meaningless until the valid bit is set.
    always_ff @(posedge clock) begin
        if (writeNow_s) begin
            tagMem_r[fillIndex_r][fillWay_r] <= fillTag_r;
        end
    end

    // Registered read port; returns pre-write contents on a same-cycle fill.
    always_ff @(posedge clock) begin
        if (reset) begin
            cacheTag_r   <= {(WAYS*tagBits){1'b0}};
            cacheValid_r <= {WAYS{1'b0}};
        end else begin
            cacheTag_r   <= lookupTags_s;
            cacheValid_r <= validMem_r[lookupIndex];
        end
    end

endmodule

// File: tb/tb_tag_fill_unit.sv
// Directed bench for tag_fill_unit: table of fills plus hand sequences for
// read-during-write, reset during eviction and touch handling.
module tb_tag_fill_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fillReq = 1'b0;
    logic        fillReady;
    logic [3:0]  fillIndex = 4'd0;
    logic [9:0]  fillTag = 10'd0;
    logic        fillDirty = 1'b0;
    logic        fillDone;
    logic [1:0]  fillWay;
    logic        evictValid;
    logic        evictReady = 1'b0;
    logic [9:0]  evictTag;
    logic [3:0]  evictIndex;
    logic [3:0]  lookupIndex = 4'd0;
    logic [39:0] cacheTag;
    logic [3:0]  cacheValid;
    logic        touchValid = 1'b0;
    logic [3:0]  touchIndex = 4'd0;
    logic [1:0]  touchWay = 2'd0;

    int vecCount  = 0;
    int missCount = 0;

    typedef struct {
        logic [3:0] idx;
        logic [9:0] tag;
        logic       dirty;
        logic [1:0] expWay;
        logic       expEvict;
        logic [9:0] expEvictTag;
        int         hold;
    } fillVec_t;

    fillVec_t vecs [10];

    tag_fill_unit dut (
        .clock       (clock),
        .reset       (reset),
        .fillReq     (fillReq),
        .fillReady   (fillReady),
        .fillIndex   (fillIndex),
        .fillTag     (fillTag),
        .fillDirty   (fillDirty),
        .fillDone    (fillDone),
        .fillWay     (fillWay),
        .evictValid  (evictValid),
        .evictReady  (evictReady),
        .evictTag    (evictTag),
        .evictIndex  (evictIndex),
        .lookupIndex (lookupIndex),
        .cacheTag    (cacheTag),
        .cacheValid  (cacheValid),
        .touchValid  (touchValid),
        .touchIndex  (touchIndex),
        .touchWay    (touchWay)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One fill transaction; inputs are scrambled after acceptance and the request held busy.
    task automatic doFill(input fillVec_t v);
        @(negedge clock);
        check("fillReady idle", 32'(fillReady), 32'd1);
        fillReq   = 1'b1;
        fillIndex = v.idx;
        fillTag   = v.tag;
        fillDirty = v.dirty;
        @(negedge clock);
        fillIndex = ~v.idx;
        fillTag   = ~v.tag;
        fillDirty = ~v.dirty;
        check("fillReady busy", 32'(fillReady), 32'd0);
        check("fillDone early", 32'(fillDone), 32'd0);
        @(negedge clock);
        if (v.expEvict) begin
            check("evictValid", 32'(evictValid), 32'd1);
            check("evictTag", 32'(evictTag), 32'(v.expEvictTag));
            check("evictIndex", 32'(evictIndex), 32'(v.idx));
            for (int c = 0; c < v.hold; c++) begin
                @(negedge clock);
                check("evictValid held", 32'(evictValid), 32'd1);
                check("evictTag held", 32'(evictTag), 32'(v.expEvictTag));
                check("fillDone in evict", 32'(fillDone), 32'd0);
            end
            evictReady = 1'b1;
            @(negedge clock);
            evictReady = 1'b0;
        end
        fillReq = 1'b0;
        check("evictValid in write", 32'(evictValid), 32'd0);
        check("fillDone", 32'(fillDone), 32'd1);
        check("fillWay", 32'(fillWay), 32'(v.expWay));
        @(negedge clock);
        check("fillDone pulse", 32'(fillDone), 32'd0);
        check("fillReady after", 32'(fillReady), 32'd1);
    endtask

    task automatic lookup(input logic [3:0] idx, input logic [3:0] expValid, input int way,
                          input logic [9:0] expTag);
        @(negedge clock);
        lookupIndex = idx;
        @(negedge clock);
        check("cacheValid", 32'(cacheValid), 32'(expValid));
        if (way >= 0) begin
            check("cacheTag", 32'(cacheTag[way*10 +: 10]), 32'(expTag));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        fillVec_t v;

        vecs[0] = '{4'd3, 10'h155, 1'b0, 2'd0, 1'b0, 10'h000, 0};
        vecs[1] = '{4'd5, 10'h001, 1'b1, 2'd0, 1'b0, 10'h000, 0};
        vecs[2] = '{4'd5, 10'h002, 1'b1, 2'd1, 1'b0, 10'h000, 0};
        vecs[3] = '{4'd5, 10'h003, 1'b1, 2'd2, 1'b0, 10'h000, 0};
        vecs[4] = '{4'd5, 10'h004, 1'b1, 2'd3, 1'b0, 10'h000, 0};
        vecs[5] = '{4'd5, 10'h005, 1'b0, 2'd0, 1'b1, 10'h001, 3};
        vecs[6] = '{4'd3, 10'h155, 1'b0, 2'd0, 1'b0, 10'h000, 0};
        vecs[7] = '{4'd5, 10'h003, 1'b1, 2'd2, 1'b0, 10'h000, 0};
        vecs[8] = '{4'd5, 10'h006, 1'b0, 2'd1, 1'b1, 10'h002, 0};
`ifdef TAG_FILL_PLRU_EN
        vecs[9] = '{4'd5, 10'h007, 1'b0, 2'd3, 1'b1, 10'h004, 1};
`else
        vecs[9] = '{4'd5, 10'h007, 1'b0, 2'd2, 1'b1, 10'h003, 1};
`endif

        repeat (2) @(negedge clock);
        check("reset fillReady", 32'(fillReady), 32'd1);
        check("reset fillDone", 32'(fillDone), 32'd0);
        check("reset evictValid", 32'(evictValid), 32'd0);
        check("reset cacheValid", 32'(cacheValid), 32'd0);
        check("reset cacheTag lo", 32'(cacheTag[31:0]), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            if (i == 9) begin
                // Touches ways 0,1,2 of set 5; only the pseudo-LRU build reacts.
                for (int t = 0; t < 3; t++) begin
                    @(negedge clock);
                    touchValid = 1'b1;
                    touchIndex = 4'd5;
                    touchWay   = 2'(t);
                end
                @(negedge clock);
                touchValid = 1'b0;
            end
            doFill(vecs[i]);
            if (i == 0) lookup(4'd3, 4'b0001, 0, 10'h155);
            if (i == 5) lookup(4'd5, 4'b1111, 0, 10'h005);
            if (i == 6) lookup(4'd3, 4'b0001, 0, 10'h155);
        end

        // Read-during-write on set 7: old contents first, new tag next cycle.
        @(negedge clock);
        lookupIndex = 4'd7;
        doFill('{4'd7, 10'h2aa, 1'b0, 2'd0, 1'b0, 10'h000, 0});
        check("rdw old valid", 32'(cacheValid), 32'd0);
        @(negedge clock);
        check("rdw new valid", 32'(cacheValid), 32'b0001);
        check("rdw new tag", 32'(cacheTag[9:0]), 32'h2aa);

        // Fill set 9 with dirty lines, then reset while the victim is offered.
        for (int k = 0; k < 4; k++) begin
            v = '{4'd9, 10'(10'h101 + k), 1'b1, 2'(k), 1'b0, 10'h000, 0};
            doFill(v);
        end
        @(negedge clock);
        check("fillReady pre-evict", 32'(fillReady), 32'd1);
        fillReq   = 1'b1;
        fillIndex = 4'd9;
        fillTag   = 10'h105;
        fillDirty = 1'b0;
        @(negedge clock);
        fillReq = 1'b0;
        @(negedge clock);
        check("evictValid before reset", 32'(evictValid), 32'd1);
        check("evictTag before reset", 32'(evictTag), 32'h101);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("evictValid after reset", 32'(evictValid), 32'd0);
        check("fillReady after reset", 32'(fillReady), 32'd1);
        check("fillDone after reset", 32'(fillDone), 32'd0);
        check("evictTag after reset", 32'(evictTag), 32'd0);
        lookup(4'd3, 4'b0000, -1, 10'h000);
        lookup(4'd5, 4'b0000, -1, 10'h000);
        lookup(4'd7, 4'b0000, -1, 10'h000);
        lookup(4'd9, 4'b0000, -1, 10'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
